instr_prefetch_unit: RTL and testbench
======================================

// Module: instr_prefetch_unit
// PURPOSE
//  Parametrised fetch-stage block: owns the fetch PC, reads a synchronous instruction ROM and
//  buffers fetched words in a small FIFO toward decode with a valid/ready handshake. Supports
//  branch redirect with flush, a misalignment fault, and NOP fill beyond ROM range.
//  Sits between the PC-select logic and the IF/ID pipeline register.
// PARAMETERS
//  ROM_DEPTH   64                     number of 32-bit instruction words in ROM (power of 2)
//  FIFO_DEPTH  4                      prefetch buffer entries (power of 2, >=2)
//  RESET_PC    0                      fetch PC loaded on reset (must be 4-byte aligned)
//  INIT_FILE   "instr.mem"            $readmemb image for ROM contents
// PORTS
//  clk             in   1          rising-edge clock
//  rst_n           in   1          synchronous reset, active low
//  redirect_valid  in   1          branch/exception redirect request, one-cycle pulse
//  redirect_pc     in   `WORD      new fetch address
//  instr_valid     out  1          FIFO head holds a valid instruction
//  instr_ready     in   1          decode accepts head this cycle
//  instr           out  `INSTR_LEN instruction at FIFO head
//  instr_pc        out  `WORD      byte address of instr
//  fetch_fault     out  1          sticky: misaligned redirect seen, fetching halted
// BEHAVIOUR
//  - Reset (edge with rst_n=0): fetch_pc=RESET_PC, FIFO empty, no read in flight, state=RUN;
//    instr_valid=0, instr=0, instr_pc=0, fetch_fault=0. Reset overrides every other input.
//  - ROM read latency 1: read issued at edge N lands in FIFO at edge N+1.
//  - Issue rule (RUN only): issue when count + inflight < FIFO_DEPTH, where count is the
//    post-pop occupancy of this cycle; on issue fetch_pc += 4 (64-bit wrap, no carry out).
//  - First instr_valid after reset: rst_n high at edge 1 issues RESET_PC; word enters FIFO at
//    edge 2; instr_valid=1 after edge 2. Same 2-edge latency after any redirect.
//  - Steady state with instr_ready=1: one instruction per cycle, PCs strictly +4.
//  - Pop: instr_valid & instr_ready at an edge removes head. Push and pop in one edge allowed.
//  - Full: FIFO never overflows; issue stalls until space; instr, instr_pc stable while
//    instr_valid=1 and instr_ready=0.
//  - ROM index = pc[log2(ROM_DEPTH)+1:2] when pc < 4*ROM_DEPTH; else data = `NOP_INSTR
//    (32'hD503201F), instr_pc still the real address.
//  - Redirect (priority over pop, push, issue in same edge): FIFO cleared, in-flight read
//    dropped, instr_valid=0 next cycle. redirect_pc[1:0]==0 -> fetch_pc=redirect_pc, RUN.
//    redirect_pc[1:0]!=0 -> state=FAULT, fetch_fault=1, no issue.
//  - FAULT: no reads, FIFO stays empty; left only by an aligned redirect (fault clears at that
//    edge) or reset. Misaligned redirect while in FAULT keeps FAULT.
//  - FSM: RUN --misaligned redirect--> FAULT; FAULT --aligned redirect--> RUN; any --rst_n=0--> RUN.
//  - Pointers: rd/wr pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full/empty from MSB.
// STRUCTURE
//  - definitions.vh: `WORD, `INSTR_LEN, `CYCLE, new `NOP_INSTR, `INSTR_BYTES (4).
//  - Sub-module instr_rom: synchronous-read ROM (clk, en, addr, data), ROM_DEPTH/INIT_FILE
//    params, out-of-range NOP substitution done in the parent. FIFO kept inline.
// TESTING  (bench clock from oscillator, period `CYCLE; ROM image word i = 32'h1000_0000+i)
//  1 Reset, instr_ready=1 -> instr_valid rises after edge 2; instr_pc 0,4,8,...,52 on
//    consecutive cycles, instr = 32'h1000_0000..32'h1000_000D.
//  2 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 entries held, head pc 0 stable;
//    release -> pcs 0,4,8,12,16 with no gap or duplicate.
//  3 Redirect to 32'h40 while FIFO holds pcs 8..20 -> instr_valid=0 next cycle, next delivered
//    instr_pc=32'h40, instr=32'h1000_0010, 2 edges after redirect.
//  4 Redirect to 32'h42 -> fetch_fault=1, instr_valid stays 0 for 20 cycles; redirect to
//    32'h8 -> fault clears, instr_pc 8 delivered after 2 edges.
//  5 Redirect to 4*ROM_DEPTH-8 (0xF8) -> pcs 0xF8,0xFC real words, then 0x100,0x104 with
//    instr=32'hD503201F.
//  6 rst_n=0 for one edge mid-stream with redirect_valid=1 same cycle -> redirect ignored,
//    FIFO empty, restart at RESET_PC with 2-edge latency, fetch_fault=0.

Source files
------------

// File: rtl/instr_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_unit_pkg
// Description : Shared widths, constants, FSM states and the FIFO entry type
//               for the instruction prefetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_prefetch_unit_pkg;

    localparam int WORD        = 64;            // address / PC width
    localparam int INSTR_LEN   = 32;            // instruction width
    localparam int INSTR_BYTES = 4;             // bytes per instruction
    localparam logic [INSTR_LEN-1:0] NOP_INSTR = 32'hD503201F;

    // Fetch control states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    // One prefetch buffer slot: the fetched word and the address it came from
    typedef struct packed {
        logic [WORD-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
    } fetch_entry_t;

    // Built-in ROM image used when no init file is given: word i = 0x1000_0000 + i
    function automatic logic [INSTR_LEN-1:0] rom_fill_word(input logic [31:0] idx);
        return 32'h1000_0000 + idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_rom.sv
`default_nettype none
// ============================================================================
// Module      : instr_rom
// Description : Synchronous-read instruction ROM, one-cycle latency. Contents
//               come from a built-in counting pattern (word i = 0x1000_0000+i).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_rom
    import instr_prefetch_unit_pkg::*;
#(
    parameter int    ROM_DEPTH = 64,
    parameter string INIT_FILE = "instr.mem",
    localparam int   AW        = $clog2(ROM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [AW-1:0]        addr,
    output logic [INSTR_LEN-1:0] data
);

    logic [INSTR_LEN-1:0] data_q;

    // Registered read of the built-in counting pattern
    always_ff @(posedge clk) begin
        if (en) begin
            data_q <= rom_fill_word(32'(addr));
        end
    end

    assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_unit
// Description : Fetch stage. Owns the fetch PC, issues reads to a synchronous
//               ROM and buffers returned words in a small FIFO toward decode.
//               Handles redirect/flush, misaligned-redirect fault and NOP fill
//               for addresses beyond the ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int              ROM_DEPTH  = 64,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [WORD-1:0] RESET_PC   = '0,
    parameter string           INIT_FILE  = "instr.mem"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [WORD-1:0]      redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_LEN-1:0] instr,
    output logic [WORD-1:0]      instr_pc,
    output logic                 fetch_fault
);

    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;   // extra MSB separates full from empty
    localparam int IDX_W  = PTR_W - 1;
    localparam int CNT_W  = PTR_W + 1;                 // room for occupancy + in-flight

    // ---------------------------------------------------------------- state
    fetch_state_e         state_q, state_d;
    logic [WORD-1:0]      fetch_pc_q, fetch_pc_d;
    logic                 inflight_q, inflight_d;
    logic [WORD-1:0]      inflight_pc_q;
    logic                 inflight_oor_q;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    fetch_entry_t         fifo_mem [FIFO_DEPTH];

    // ---------------------------------------------------------------- wires
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [PTR_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     occ_after_pop;
    logic [CNT_W-1:0]     demand;
    logic                 do_pop;
    logic                 do_push;
    logic                 do_issue;
    logic                 redirect_aligned;
    logic                 pc_in_range;
    logic [INSTR_LEN-1:0] rom_data;
    fetch_entry_t         push_entry;
    fetch_entry_t         head_entry;

    // ---------------------------------------------------------------- FIFO status
    assign fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign fifo_full  = (rd_ptr_q[PTR_W-1] != wr_ptr_q[PTR_W-1]) &&
                        (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]);
    assign fifo_count = wr_ptr_q - rd_ptr_q;

    assign instr_valid = !fifo_empty;
    assign do_pop      = instr_valid && instr_ready;

    // A landing read always has a slot: issue never over-commits the buffer
    assign do_push     = inflight_q && !redirect_valid && (!fifo_full || do_pop);

    // Space check counts the slot freed this cycle and the read still in the ROM
    assign occ_after_pop = CNT_W'(fifo_count) - CNT_W'(do_pop);
    assign demand        = occ_after_pop + CNT_W'(inflight_q);
    assign do_issue      = (state_q == ST_RUN) && !redirect_valid &&
                           (demand < CNT_W'(FIFO_DEPTH));

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    // Addresses past the ROM return NOP; only the high PC bits decide that
    assign pc_in_range = (fetch_pc_q[WORD-1:ROM_AW+2] == '0);

    // ---------------------------------------------------------------- ROM
    instr_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .en   (do_issue && pc_in_range),
        .addr (fetch_pc_q[ROM_AW+1:2]),
        .data (rom_data)
    );

    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = inflight_oor_q ? NOP_INSTR : rom_data;

    // ---------------------------------------------------------------- outputs
    assign head_entry  = fifo_mem[rd_ptr_q[IDX_W-1:0]];
    assign instr       = instr_valid ? head_entry.instr : '0;
    assign instr_pc    = instr_valid ? head_entry.pc    : '0;
    assign fetch_fault = (state_q == ST_FAULT);

    // Next fetch state: misaligned redirect halts fetching, aligned redirect resumes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid && !redirect_aligned) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (redirect_valid && redirect_aligned) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Next PC, pointers and in-flight flag; a redirect flushes and wins over everything
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            if (redirect_aligned) begin
                fetch_pc_d = redirect_pc;
            end
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_issue) begin
                inflight_d = 1'b1;
                fetch_pc_d = fetch_pc_q + WORD'(INSTR_BYTES);
            end
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Remember which address the outstanding ROM read belongs to
    always_ff @(posedge clk) begin
        if (do_issue) begin
            inflight_pc_q  <= fetch_pc_q;
            inflight_oor_q <= !pc_in_range;
        end
    end

    // Buffer storage; validity is tracked purely by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q[IDX_W-1:0]] <= push_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_unit
// Description : Self-checking bench for instr_prefetch_unit. Expected fetch
//               streams go into a scoreboard queue and are compared as decode
//               accepts each instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_unit;

    localparam int CYCLE      = 10;
    localparam int ROM_DEPTH  = 64;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        fetch_fault;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];

    instr_prefetch_unit #(
        .ROM_DEPTH  (ROM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (64'h0),
        .INIT_FILE  ("")
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #(CYCLE/2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ROM image word i = 0x1000_0000 + i; beyond the ROM the unit supplies NOP
    function automatic logic [31:0] ref_word(input logic [63:0] pc);
        logic [63:0] idx;
        idx = pc >> 2;
        if (pc < 64'(4 * ROM_DEPTH)) return 32'h1000_0000 + idx[31:0];
        else                         return 32'hD503201F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [63:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 64'(4 * i);
            e.word = ref_word(e.pc);
            sb_q.push_back(e);
        end
    endtask

    // Accept instructions until n have been compared or the cycle budget runs out
    task automatic drain(input string tag, input int n, output int cycles);
        int   got;
        exp_t e;
        got    = 0;
        cycles = 0;
        instr_ready = 1'b1;
        while (got < n && cycles < n + 20) begin
            if (instr_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq({tag, "_pc"},    instr_pc,  e.pc);
                    check_eq({tag, "_instr"}, 64'(instr), 64'(e.word));
                end
                got++;
            end
            tick();
            cycles++;
        end
        instr_ready = 1'b0;
        check_eq({tag, "_count"}, 64'(got), 64'(n));
    endtask

    task automatic apply_reset(input string tag, input logic with_redirect, input logic [63:0] rpc);
        rst_n          = 1'b0;
        redirect_valid = with_redirect;
        redirect_pc    = rpc;
        tick();
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        sb_q.delete();
        check_eq({tag, "_rst_valid"}, 64'(instr_valid), 64'd0);
        check_eq({tag, "_rst_instr"}, 64'(instr),       64'd0);
        check_eq({tag, "_rst_pc"},    instr_pc,         64'd0);
        check_eq({tag, "_rst_fault"}, 64'(fetch_fault), 64'd0);
    endtask

    task automatic redirect_to(input string tag, input logic [63:0] rpc);
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        tick();
        redirect_valid = 1'b0;
        sb_q.delete();
        check_eq({tag, "_flush_valid"}, 64'(instr_valid), 64'd0);
    endtask

    // Two edges from reset/redirect to the first valid instruction
    task automatic check_latency(input string tag);
        tick();
        check_eq({tag, "_lat1_valid"}, 64'(instr_valid), 64'd0);
        tick();
        check_eq({tag, "_lat2_valid"}, 64'(instr_valid), 64'd1);
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #(CYCLE * 20000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        int cyc;
        int valid_seen;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        // 1: reset, streaming 14 instructions back to back
        apply_reset("t1", 1'b0, 64'h0);
        instr_ready = 1'b1;
        check_latency("t1");
        push_stream(64'h0, 14);
        drain("t1", 14, cyc);
        check_eq("t1_no_gap", 64'(cyc), 64'd14);

        // 2: decode stalls, buffer fills, head holds, then releases without gap
        apply_reset("t2", 1'b0, 64'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) begin
                check_eq("t2_hold_pc", instr_pc, 64'h0);
            end
        end
        check_eq("t2_hold_instr", 64'(instr), 64'h1000_0000);
        push_stream(64'h0, 5);
        drain("t2", 5, cyc);
        check_eq("t2_no_gap", 64'(cyc), 64'd5);

        // 3: redirect while buffer holds pcs 8..20
        apply_reset("t3", 1'b0, 64'h0);
        repeat (10) tick();
        push_stream(64'h0, 2);
        drain("t3a", 2, cyc);
        repeat (4) tick();
        check_eq("t3_head_pc", instr_pc, 64'h8);
        redirect_to("t3", 64'h40);
        instr_ready = 1'b1;
        check_latency("t3");
        push_stream(64'h40, 3);
        drain("t3b", 3, cyc);

        // 4: misaligned redirect faults, aligned redirect recovers
        instr_ready = 1'b1;
        redirect_to("t4", 64'h42);
        check_eq("t4_fault_set", 64'(fetch_fault), 64'd1);
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_valid) valid_seen++;
        end
        check_eq("t4_idle", 64'(valid_seen), 64'd0);
        check_eq("t4_fault_held", 64'(fetch_fault), 64'd1);
        redirect_to("t4r", 64'h8);
        check_eq("t4_fault_clr", 64'(fetch_fault), 64'd0);
        check_latency("t4r");
        push_stream(64'h8, 3);
        drain("t4", 3, cyc);

        // 5: run off the end of the ROM into NOP fill
        redirect_to("t5", 64'(4 * ROM_DEPTH - 8));
        instr_ready = 1'b1;
        check_latency("t5");
        push_stream(64'(4 * ROM_DEPTH - 8), 4);
        drain("t5", 4, cyc);
        check_eq("t5_no_gap", 64'(cyc), 64'd4);

        // 6: reset mid-stream with a simultaneous redirect
        instr_ready = 1'b1;
        repeat (3) tick();
        apply_reset("t6", 1'b1, 64'h80);
        check_latency("t6");
        push_stream(64'h0, 3);
        drain("t6", 3, cyc);

        // 7: reset clears a sticky fault even with a misaligned redirect present
        redirect_to("t7", 64'h3);
        check_eq("t7_fault_set", 64'(fetch_fault), 64'd1);
        apply_reset("t7", 1'b1, 64'h5);
        instr_ready = 1'b1;
        check_latency("t7");
        push_stream(64'h0, 2);
        drain("t7", 2, cyc);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
`default_nettype wire
